// File: rtl/ps2_key_ctrl_if.sv
// Event queue handshake between the PS/2 key controller and game logic.
// master drives the head event; slave accepts it with evt_ready.
interface ps2_key_ctrl_if;
   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_make;

   modport master (
      output evt_valid,
      output evt_code,
      output evt_ext,
      output evt_make,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_code,
      input  evt_ext,
      input  evt_make,
      output evt_ready
   );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan byte sequencer: E0/F0 prefix FSM with watchdog,
// held-key vector for game controls and a small event FIFO.
module ps2_key_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 50000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   input  logic        byte_err,
   ps2_key_ctrl_if.master evt,
   output logic        key_left,
   output logic        key_right,
   output logic        key_space,
   output logic        key_esc,
   output logic        overflow,
   output logic [1:0]  fsm_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } st_t;

   st_t           st;
   st_t           st_nxt;
   logic [CW-1:0] tcnt;
   logic          tout;
   logic          is_e0;
   logic          is_f0;
   logic          is_junk;
   logic          emit;
   logic          e_ext;
   logic          e_make;
   logic          hit_l;
   logic          hit_r;
   logic          hit_s;
   logic          hit_e;

   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;
   logic          full;
   logic          nonempty;
   logic          pop;
   logic          wr;

   assign is_e0   = byte_in == 8'hE0;
   assign is_f0   = byte_in == 8'hF0;
   assign is_junk = byte_in inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE};
   assign tout    = (st != IDLE) && (tcnt == TO_LAST);

   always_comb begin
      st_nxt = st;
      emit   = 1'b0;
      e_ext  = 1'b0;
      e_make = 1'b0;
      if (byte_valid && byte_err) begin
         st_nxt = IDLE;
      end else if (byte_valid) begin
         unique case (st)
            IDLE: begin
               if (is_e0) begin
                  st_nxt = EXT;
               end else if (is_f0) begin
                  st_nxt = BRK;
               end else if (!is_junk) begin
                  emit   = 1'b1;
                  e_make = 1'b1;
               end
            end
            EXT: begin
               if (is_f0) begin
                  st_nxt = EXT_BRK;
               end else if (!is_e0) begin
                  emit   = 1'b1;
                  e_ext  = 1'b1;
                  e_make = 1'b1;
                  st_nxt = IDLE;
               end
            end
            BRK: begin
               if (!is_f0) begin
                  emit   = 1'b1;
                  st_nxt = IDLE;
               end
            end
            EXT_BRK: begin
               if (!is_f0 && !is_e0) begin
                  emit   = 1'b1;
                  e_ext  = 1'b1;
                  st_nxt = IDLE;
               end
            end
         endcase
      end else if (tout) begin
         st_nxt = IDLE;
      end
   end

   assign hit_l = e_ext ? (byte_in == 8'h6B) : (byte_in == 8'h1C);
   assign hit_r = e_ext ? (byte_in == 8'h74) : (byte_in == 8'h23);
   assign hit_s = !e_ext && (byte_in == 8'h29);
   assign hit_e = !e_ext && (byte_in == 8'h76);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         st   <= IDLE;
         tcnt <= '0;
      end else begin
         st <= st_nxt;
         if (byte_valid || st == IDLE || tout) begin
            tcnt <= '0;
         end else begin
            tcnt <= tcnt + 1'b1;
         end
      end
   end

   // Key bits follow every decoded event, even one the FIFO drops.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         key_left  <= 1'b0;
         key_right <= 1'b0;
         key_space <= 1'b0;
         key_esc   <= 1'b0;
      end else if (emit) begin
         if (hit_l) key_left  <= e_make;
         if (hit_r) key_right <= e_make;
         if (hit_s) key_space <= e_make;
         if (hit_e) key_esc   <= e_make;
      end
   end

   assign full     = cnt == FULL_CNT;
   assign nonempty = cnt != '0;
   assign pop      = nonempty && evt.evt_ready;
   assign wr       = emit && (!full || pop);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wp       <= '0;
         rp       <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr) begin
            mem[wp] <= {e_ext, e_make, byte_in};
            wp      <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
         if (emit && full && !pop) overflow <= 1'b1;
         if (wr && !pop) begin
            cnt <= cnt + 1'b1;
         end else if (pop && !wr) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign evt.evt_valid = nonempty;
   assign evt.evt_ext   = mem[rp][9];
   assign evt.evt_make  = mem[rp][8];
   assign evt.evt_code  = mem[rp][7:0];
   assign fsm_state     = st;

endmodule
